pla_toggle_monitor: RTL and testbench
=====================================

PLA_TOGGLE_MONITOR -- requirements
Module: pla_toggle_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 14, giving the PLA output word width consumed.
REQ-002 SHALL have parameter CNT_W, default 20, giving the toggle accumulator width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begins a measurement window; in DONE it also acknowledges results.
REQ-006 SHALL have port window_len  input  16  number of samples per window, sampled when start is accepted.
REQ-007 SHALL have port in_valid  input  1  upstream PLA output word valid.
REQ-008 SHALL have port in_word  input  WIDTH  PLA output word (v5.0 at bit 0 ... v5.13 at bit 13).
REQ-009 SHALL have port in_ready  output  1  monitor accepts a word this cycle.
REQ-010 SHALL have port out_valid  output  1  results are held and valid.
REQ-011 SHALL have port toggle_total  output  CNT_W  saturating sum of per-sample bit toggles.
REQ-012 SHALL have port toggle_max  output  5  largest per-sample toggle count in the window.
REQ-013 SHALL have port sample_count  output  16  words accepted in the current window.
REQ-014 SHALL have port signature  output  WIDTH  MISR compaction of accepted words.
REQ-015 SHALL have port sat  output  1  toggle_total saturated during the window.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 -> RUN and clear prev_word, toggle_total, toggle_max, sample_count, signature and sat to 0; latch window_len, with 0 treated as 1.
REQ-018 RUN: in_ready=1; a word is accepted only when in_valid=1 and in_ready=1 in the same cycle.
REQ-019 Per accepted word: t = popcount(in_word XOR prev_word), then prev_word <= in_word and sample_count += 1.
REQ-020 On the same edge, toggle_total += t, saturating at 2^CNT_W-1; sat is set on saturation and stays set until the next start.
REQ-021 On the same edge, toggle_max <= max(toggle_max, t).
REQ-022 Signature update: fb = sig[13]^sig[9]^sig[5]^sig[0]; sig <= ({sig[12:0],fb}) XOR in_word.
REQ-023 When the accepted word makes sample_count equal the latched window_len, the state SHALL go to DONE on the same edge.
REQ-024 Latency: out_valid=1 in the cycle after the final accepted word.
REQ-025 DONE: in_ready=0, out_valid=1, and all result outputs are held stable.
REQ-026 In DONE, start=1 performs the IDLE start action (clear, latch, -> RUN); out_valid drops on that edge.
REQ-027 start in RUN SHALL be ignored.
REQ-028 Cycles with in_valid=0 SHALL leave all state unchanged.
REQ-029 Result outputs SHALL be registered, with no combinational path from in_word.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, with in_ready, out_valid, toggle_total, toggle_max, sample_count, signature, sat and prev_word all 0, regardless of state.
REQ-031 Deassertion mid-window SHALL discard the partial window; the block then waits for a fresh start.

Verification
REQ-032 Reset: assert rst_n=0 in RUN mid-window -> all outputs 0 asynchronously; after release, in_ready=0 until start.
REQ-033 Basic window: start, window_len=4, words 0x0000,0x3FFF,0x0000,0x0001 back-to-back -> toggle_total=29, toggle_max=14, sample_count=4, signature=0x3FFC, sat=0, out_valid=1 one cycle after the 4th word.
REQ-034 Stalls: same words as REQ-033 with in_valid gaps of 0-3 cycles -> identical results; sample_count advances only on accepted cycles.
REQ-035 Saturation: CNT_W=5, window_len=4, words 0x3FFF,0x0000,0x3FFF,0x0000 -> toggle_total=31, sat=1, toggle_max=14.
REQ-036 Restart and ignore: start pulsed in RUN -> no effect; start in DONE -> out_valid=0 next cycle, counters cleared, new window runs.
REQ-037 window_len=0: one accepted word 0x0005 -> DONE, toggle_total=2, sample_count=1, signature=0x0005.

Source files
------------

// File: rtl/pla_toggle_monitor.sv
// PLA output toggle monitor: counts per-sample bit toggles over a window of
// accepted words and compacts them into a MISR signature.
module pla_toggle_monitor #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      window_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_total,
  output logic [4:0]       toggle_max,
  output logic [15:0]      sample_count,
  output logic [WIDTH-1:0] signature,
  output logic             sat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev_word;
  logic [15:0]      win_len;
  logic [WIDTH-1:0] diff;
  logic [4:0]       t;
  logic [CNT_W:0]   sum;
  logic             fb;
  logic             accept;

  assign in_ready = (state == S_RUN);
  assign accept   = in_ready && in_valid;

  always_comb begin
    diff = in_word ^ prev_word;
    t    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t = t + 5'(diff[i]);
    end
    // One extra bit catches the carry that signals saturation.
    sum = {1'b0, toggle_total} + (CNT_W+1)'(t);
    fb  = signature[WIDTH-1] ^ signature[9] ^ signature[5] ^ signature[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      prev_word    <= '0;
      win_len      <= '0;
      out_valid    <= 1'b0;
      toggle_total <= '0;
      toggle_max   <= '0;
      sample_count <= '0;
      signature    <= '0;
      sat          <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RUN;
            prev_word    <= '0;
            win_len      <= (window_len == 16'd0) ? 16'd1 : window_len;
            out_valid    <= 1'b0;
            toggle_total <= '0;
            toggle_max   <= '0;
            sample_count <= '0;
            signature    <= '0;
            sat          <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            prev_word    <= in_word;
            sample_count <= sample_count + 16'd1;
            if (sum[CNT_W]) begin
              toggle_total <= '1;
              sat          <= 1'b1;
            end else begin
              toggle_total <= sum[CNT_W-1:0];
            end
            if (t > toggle_max) toggle_max <= t;
            signature <= {signature[WIDTH-2:0], fb} ^ in_word;
            if (sample_count + 16'd1 == win_len) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_toggle_monitor.sv
// Bench for pla_toggle_monitor: directed and random windows checked against a
// queue-based reference model, on a default instance and a CNT_W=5 instance.
module tb_pla_toggle_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window_len = '0;
  logic        in_valid = 1'b0;
  logic [13:0] in_word = '0;

  logic        a_ready, a_valid, a_sat, b_ready, b_valid, b_sat;
  logic [19:0] a_total;
  logic [4:0]  b_total;
  logic [4:0]  a_max, b_max;
  logic [15:0] a_cnt, b_cnt;
  logic [13:0] a_sig, b_sig;

  pla_toggle_monitor #(.WIDTH(14), .CNT_W(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .in_valid(in_valid), .in_word(in_word), .in_ready(a_ready),
    .out_valid(a_valid), .toggle_total(a_total), .toggle_max(a_max),
    .sample_count(a_cnt), .signature(a_sig), .sat(a_sat)
  );

  pla_toggle_monitor #(.WIDTH(14), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .in_valid(in_valid), .in_word(in_word), .in_ready(b_ready),
    .out_valid(b_valid), .toggle_total(b_total), .toggle_max(b_max),
    .sample_count(b_cnt), .signature(b_sig), .sat(b_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [13:0] acc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-window reference computed from the list of accepted words.
  function automatic void model(input int cw, output logic [31:0] tot,
                                output logic [31:0] mx, output logic [31:0] sg,
                                output logic [31:0] st);
    int unsigned prev, sum, cap, t, sig, fb;
    prev = 0; sum = 0; sig = 0;
    cap = (32'd1 << cw) - 1;
    mx = 0; st = 0;
    foreach (acc[k]) begin
      t = $countones((int'(acc[k]) ^ prev) & 32'h3FFF);
      sum = sum + t;
      if (sum > cap) begin
        sum = cap;
        st = 1;
      end
      if (t > mx) mx = t;
      fb  = ((sig >> 13) ^ (sig >> 9) ^ (sig >> 5) ^ sig) & 1;
      sig = (((sig << 1) & 32'h3FFF) | fb) ^ int'(acc[k]);
      prev = int'(acc[k]);
    end
    tot = sum;
    sg  = sig;
  endfunction

  task automatic check_results(input string tag);
    logic [31:0] tot, mx, sg, st;
    model(20, tot, mx, sg, st);
    chk({tag, "_a_total"}, 32'(a_total), tot);
    chk({tag, "_a_max"},   32'(a_max),   mx);
    chk({tag, "_a_sig"},   32'(a_sig),   sg);
    chk({tag, "_a_sat"},   32'(a_sat),   st);
    chk({tag, "_a_cnt"},   32'(a_cnt),   32'(acc.size()));
    chk({tag, "_a_valid"}, 32'(a_valid), 32'd1);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    model(5, tot, mx, sg, st);
    chk({tag, "_b_total"}, 32'(b_total), tot);
    chk({tag, "_b_max"},   32'(b_max),   mx);
    chk({tag, "_b_sat"},   32'(b_sat),   st);
    chk({tag, "_b_valid"}, 32'(b_valid), 32'd1);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic start_window(input logic [15:0] len);
    start = 1'b1;
    window_len = len;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc.delete();
    chk("start_ready", 32'(a_ready), 32'd1);
    chk("start_valid", 32'(a_valid), 32'd0);
    chk("start_cnt",   32'(a_cnt),   32'd0);
    chk("start_total", 32'(a_total), 32'd0);
    chk("start_sig",   32'(a_sig),   32'd0);
  endtask

  task automatic send(input logic [13:0] w, input int gap, input logic pulse, input logic last);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_word = 14'($urandom);
      @(negedge clk);
      chk("gap_cnt",   32'(a_cnt),   32'(acc.size()));
      chk("gap_ready", 32'(a_ready), 32'd1);
    end
    in_valid = 1'b1;
    in_word = w;
    start = pulse;
    window_len = 16'($urandom_range(1, 3));
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    acc.push_back(w);
    chk("acc_cnt", 32'(a_cnt), 32'(acc.size()));
    if (!last) chk("run_valid", 32'(a_valid), 32'd0);
  endtask

  task automatic run_window(input logic [15:0] len, input logic [13:0] words[$],
                            input int maxgap, input logic pulse_ok, input string tag);
    start_window(len);
    foreach (words[k]) begin
      send(words[k], $urandom_range(0, maxgap),
           pulse_ok && ($urandom_range(0, 2) == 0), k == words.size() - 1);
    end
    check_results(tag);
    // Words offered in DONE are refused and results hold.
    in_valid = 1'b1;
    in_word = 14'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    check_results({tag, "_hold"});
  endtask

  initial begin
    logic [13:0] q[$];
    int len;

    @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_total", 32'(a_total), 32'd0);
    chk("rst_sig",   32'(a_sig),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", 32'(a_ready), 32'd0);

    q = '{14'h0000, 14'h3FFF, 14'h0000, 14'h0001};
    run_window(16'd4, q, 0, 1'b0, "basic");
    chk("basic_total_c", 32'(a_total), 32'd29);
    chk("basic_max_c",   32'(a_max),   32'd14);
    chk("basic_sig_c",   32'(a_sig),   32'h3FFC);

    run_window(16'd4, q, 3, 1'b0, "stall");
    chk("stall_sig_c", 32'(a_sig), 32'h3FFC);

    q = '{14'h3FFF, 14'h0000, 14'h3FFF, 14'h0000};
    run_window(16'd4, q, 1, 1'b0, "satw");
    chk("sat_total_c", 32'(b_total), 32'd31);
    chk("sat_flag_c",  32'(b_sat),   32'd1);
    chk("sat_max_c",   32'(b_max),   32'd14);
    chk("nosat_a_c",   32'(a_sat),   32'd0);

    q = '{14'h0005};
    run_window(16'd0, q, 0, 1'b0, "len0");
    chk("len0_total_c", 32'(a_total), 32'd2);
    chk("len0_cnt_c",   32'(a_cnt),   32'd1);
    chk("len0_sig_c",   32'(a_sig),   32'h0005);

    q = '{14'h1234, 14'h0F0F, 14'h3C3C, 14'h2001, 14'h0777, 14'h3FFF};
    run_window(16'd6, q, 2, 1'b1, "restart");

    // Reset asserted mid-window clears outputs without waiting for a clock.
    start_window(16'd10);
    send(14'h1111, 0, 1'b0, 1'b0);
    send(14'h2AAA, 1, 1'b0, 1'b0);
    send(14'h0F00, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(a_ready), 32'd0);
    chk("arst_valid", 32'(a_valid), 32'd0);
    chk("arst_total", 32'(a_total), 32'd0);
    chk("arst_max",   32'(a_max),   32'd0);
    chk("arst_cnt",   32'(a_cnt),   32'd0);
    chk("arst_sig",   32'(a_sig),   32'd0);
    chk("arst_sat",   32'(b_sat),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_word = 14'h3FFF;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_ready", 32'(a_ready), 32'd0);
    chk("post_rst_cnt",   32'(a_cnt),   32'd0);
    chk("post_rst_valid", 32'(a_valid), 32'd0);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 20);
      q.delete();
      for (int k = 0; k < len; k++) q.push_back(14'($urandom));
      run_window(16'(len), q, 2, 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
